// File: rtl/fp_mul_round_status.sv
// Round/exception back-end of the single-precision multiplier.
// Stage 1 normalises and rounds the raw product; stage 2 resolves specials and packs z/status.
module fp_mul_round_status #(
  parameter int EXP_W = 10,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [47:0]      in_mant,
  input  logic [1:0]       in_a_cls,
  input  logic [1:0]       in_b_cls,
  input  logic [2:0]       in_rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [7:0]       out_status
);
  localparam int EW = EXP_W + 1;
  localparam logic signed [EW-1:0] L_EMAX = EW'(2*BIAS + 1);
  localparam logic [1:0] CLS_ZERO = 2'b01, CLS_INF = 2'b10, CLS_NAN = 2'b11;

  logic                 r_s1_v, r_s1_sign, r_s1_inx;
  logic signed [EW-1:0] r_s1_exp;
  logic [22:0]          r_s1_frac;
  logic [1:0]           r_s1_acls, r_s1_bcls;
  logic [2:0]           r_s1_rnd;
  logic                 r_s2_v;
  logic [31:0]          r_z;
  logic [7:0]           r_st;

  logic w_s2_en, w_s1_en;
  assign w_s2_en  = !r_s2_v || out_ready;
  assign w_s1_en  = !r_s1_v || w_s2_en;
  assign in_ready = w_s1_en;

  // ---------------- stage 1: normalise + round
  logic                 w_hi, w_g, w_s, w_inc;
  logic [22:0]          w_frac;
  logic [2:0]           w_rnd;
  logic [23:0]          w_sum;
  logic signed [EW-1:0] w_exp;

  assign w_hi   = in_mant[47];
  assign w_frac = w_hi ? in_mant[46:24] : in_mant[45:23];
  assign w_g    = w_hi ? in_mant[23]    : in_mant[22];
  assign w_s    = w_hi ? |in_mant[22:0] : |in_mant[21:0];
  assign w_rnd  = (in_rnd > 3'd5) ? 3'd0 : in_rnd;

  always_comb begin
    w_inc = 1'b0;
    case (w_rnd)
      3'd0:    w_inc = w_g & (w_s | w_frac[0]);
      3'd1:    w_inc = 1'b0;
      3'd2:    w_inc = (w_g | w_s) & !in_sign;
      3'd3:    w_inc = (w_g | w_s) & in_sign;
      3'd4:    w_inc = w_g;
      default: w_inc = w_g | w_s;
    endcase
  end

  // a fraction carry leaves w_sum[22:0] already zero
  assign w_sum = {1'b0, w_frac} + {23'd0, w_inc};
  assign w_exp = $signed({in_exp[EXP_W-1], in_exp})
               + $signed({{(EW-1){1'b0}}, w_hi})
               + $signed({{(EW-1){1'b0}}, w_sum[23]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_inx  <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_frac <= '0;
      r_s1_acls <= '0;
      r_s1_bcls <= '0;
      r_s1_rnd  <= '0;
    end else if (w_s1_en) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign;
        r_s1_inx  <= w_g | w_s;
        r_s1_exp  <= w_exp;
        r_s1_frac <= w_sum[22:0];
        r_s1_acls <= in_a_cls;
        r_s1_bcls <= in_b_cls;
        r_s1_rnd  <= w_rnd;
      end
    end
  end

  // ---------------- stage 2: exceptions + pack
  logic        w_near, w_away, w_nan, w_inf, w_zero;
  logic [31:0] w_z;
  logic [7:0]  w_st;

  assign w_near = (r_s1_rnd == 3'd0) || (r_s1_rnd == 3'd4);
  assign w_away = (r_s1_rnd == 3'd5) || (r_s1_rnd == 3'd2 && !r_s1_sign)
               || (r_s1_rnd == 3'd3 && r_s1_sign);
  assign w_nan  = (r_s1_acls == CLS_NAN) || (r_s1_bcls == CLS_NAN)
               || (r_s1_acls == CLS_ZERO && r_s1_bcls == CLS_INF)
               || (r_s1_acls == CLS_INF && r_s1_bcls == CLS_ZERO);
  assign w_inf  = (r_s1_acls == CLS_INF) || (r_s1_bcls == CLS_INF);
  assign w_zero = (r_s1_acls == CLS_ZERO) || (r_s1_bcls == CLS_ZERO);

  // status layout: [5]inexact [4]huge [3]tiny [2]nan [1]inf [0]zero
  always_comb begin
    w_z  = {r_s1_sign, r_s1_exp[7:0], r_s1_frac};
    w_st = {2'b00, r_s1_inx, 5'b00000};
    if (w_nan) begin
      w_z  = 32'h7FC0_0000;
      w_st = 8'h04;
    end else if (w_inf) begin
      w_z  = {r_s1_sign, 8'hFF, 23'd0};
      w_st = 8'h02;
    end else if (w_zero) begin
      w_z  = {r_s1_sign, 31'd0};
      w_st = 8'h01;
    end else if (r_s1_exp >= L_EMAX) begin
      if (w_near || w_away) begin
        w_z  = {r_s1_sign, 8'hFF, 23'd0};
        w_st = 8'h32;
      end else begin
        w_z  = {r_s1_sign, 8'hFE, {23{1'b1}}};
        w_st = 8'h30;
      end
    end else if (r_s1_exp <= $signed(EW'(0))) begin
      if (w_away) begin
        w_z  = {r_s1_sign, 8'h01, 23'd0};
        w_st = 8'h28;
      end else begin
        w_z  = {r_s1_sign, 31'd0};
        w_st = 8'h29;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_z    <= '0;
      r_st   <= '0;
    end else if (w_s2_en) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_z  <= w_z;
        r_st <= w_st;
      end
    end
  end

  assign out_valid  = r_s2_v;
  assign out_z      = r_z;
  assign out_status = r_st;
endmodule
